bram_rd_streamer: RTL and testbench

- Read-side controller and stream adapter for a single RAMB18E2 port A. The BRAM is configured as 18-bit read width with DOA_REG=1.
- Given a base address and a word count, it generates sequential read addresses and tracks the fixed BRAM read latency.
- Returned words land in a small credit-protected FIFO and are presented as a valid/ready stream to the downstream compute stage.
- Sits directly between the weight/activation BRAM and the consuming PE array.

---
 rtl/bram_rd_pkg.sv | 24 ++
 rtl/bram_rd_streamer_stream_fifo.sv | 61 ++++++
 rtl/bram_rd_streamer.sv | 226 ++++++++++++++++++++++
 tb/tb_bram_rd_streamer.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bram_rd_pkg.sv
// Shared types and defaults for the BRAM read streamer.
// Optional looping is enabled by defining BRAM_RD_STREAMER_LOOP_EN.
package bram_rd_pkg;

    localparam int DEF_WID_W      = 16;
    localparam int DEF_WID_WADDR  = 10;
    localparam int DEF_RD_LAT     = 2;
    localparam int DEF_FIFO_DEPTH = 4;

    // Width needed to hold a count from 0 up to and including depth.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    localparam int DEF_CNT_W = $clog2(DEF_FIFO_DEPTH) + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/bram_rd_streamer_stream_fifo.sv
// Small synchronous FIFO with a combinational head (first-word fall-through).
// The writer is credit-controlled, so no full flag is provided.
module stream_fifo
    import bram_rd_pkg::*;
#(
    parameter int WID   = 17,
    parameter int DEPTH = 4
) (
    input  logic                         clk_l,
    input  logic                         rst_n,
    input  logic                         push_i,
    input  logic [WID-1:0]               push_data_i,
    input  logic                         pop_i,
    output logic [WID-1:0]               head_o,
    output logic                         empty_o,
    output logic [cnt_width(DEPTH)-1:0]  count_o
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = cnt_width(DEPTH);

    logic [WID-1:0]   mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_pop;

    assign do_pop  = pop_i & (count_q != '0);
    assign head_o  = mem_q[rd_ptr_q];
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

    // Storage write; contents need no reset since count gates visibility.
    always_ff @(posedge clk_l) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    // Pointer and occupancy bookkeeping; simultaneous push and pop both take effect.
    always_ff @(posedge clk_l) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({push_i, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/bram_rd_streamer.sv
// Sequential BRAM reader feeding a credit-protected valid/ready stream.
// Define BRAM_RD_STREAMER_LOOP_EN to add the reps port (repeat the pass reps times).
module bram_rd_streamer
    import bram_rd_pkg::*;
#(
    parameter int WID_W      = DEF_WID_W,
    parameter int WID_WADDR  = DEF_WID_WADDR,
    parameter int RD_LAT     = DEF_RD_LAT,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                 clk_l,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WID_WADDR-1:0] base_addr,
    input  logic [WID_WADDR:0]   len,
`ifdef BRAM_RD_STREAMER_LOOP_EN
    input  logic [7:0]           reps,
`endif
    output logic                 busy,
    output logic                 done,
    output logic [WID_WADDR-1:0] bram_addr,
    output logic                 bram_en,
    output logic                 bram_rst,
    input  logic [WID_W-1:0]     bram_dout,
    output logic [WID_W-1:0]     m_data,
    output logic                 m_valid,
    output logic                 m_last,
    input  logic                 m_ready
);

    localparam int CNT_W = cnt_width(FIFO_DEPTH);
    localparam int OCC_W = cnt_width(FIFO_DEPTH + RD_LAT + 1);
    localparam logic [WID_WADDR:0] REM_ONE = 1;

    state_t                state_q, state_d;
    logic [WID_WADDR-1:0]  rd_ptr_q, rd_ptr_d;
    logic [WID_WADDR:0]    rem_q, rem_d;
    logic                  bram_en_q, bram_en_d;
    logic [WID_WADDR-1:0]  bram_addr_q, bram_addr_d;
    logic                  last_q, last_d;
    logic [RD_LAT-1:0]     trk_vld_q;
    logic [RD_LAT-1:0]     trk_last_q;

`ifdef BRAM_RD_STREAMER_LOOP_EN
    logic [WID_WADDR-1:0]  base_q, base_d;
    logic [WID_WADDR:0]    len_q, len_d;
    logic [7:0]            pass_q, pass_d;
    logic [WID_WADDR-1:0]  cur_base;
    logic [WID_WADDR:0]    cur_len;
    logic [7:0]            cur_pass;
`endif

    logic [WID_WADDR-1:0]  cur_ptr;
    logic [WID_WADDR:0]    cur_rem;
    logic                  can_issue;
    logic                  pass_end;
    logic                  final_word;
    logic [OCC_W-1:0]      inflight;
    logic                  credit_ok;

    logic [WID_W:0]        fifo_head;
    logic                  fifo_empty;
    logic [CNT_W-1:0]      fifo_count;
    logic                  fifo_push;
    logic                  fifo_pop;

    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);
    assign bram_en   = bram_en_q;
    assign bram_addr = bram_addr_q;
    assign bram_rst  = ~rst_n;

    assign m_valid   = ~fifo_empty;
    assign m_data    = fifo_head[WID_W-1:0];
    assign m_last    = fifo_head[WID_W] & ~fifo_empty;
    assign fifo_pop  = m_valid & m_ready;
    assign fifo_push = trk_vld_q[RD_LAT-1];

    // Credit: every word on the bus or in the tracker already owns a FIFO slot.
    always_comb begin
        inflight = OCC_W'(bram_en_q);
        for (int i = 0; i < RD_LAT; i++) begin
            inflight = inflight + OCC_W'(trk_vld_q[i]);
        end
        credit_ok = (OCC_W'(fifo_count) + inflight - OCC_W'(fifo_pop)) < OCC_W'(FIFO_DEPTH);
    end

    // Issue decision; in IDLE the first word is issued straight from the start inputs.
    always_comb begin
        cur_ptr = rd_ptr_q;
        cur_rem = rem_q;
`ifdef BRAM_RD_STREAMER_LOOP_EN
        cur_base = base_q;
        cur_len  = len_q;
        cur_pass = pass_q;
        if (state_q == ST_IDLE) begin
            cur_base = base_addr;
            cur_len  = len;
            cur_pass = (reps == 8'd0) ? 8'd1 : reps;
        end
`endif
        if (state_q == ST_IDLE) begin
            cur_ptr = base_addr;
            cur_rem = len;
        end
        can_issue = (((state_q == ST_IDLE) & start) | (state_q == ST_RUN))
                    & (cur_rem != '0) & credit_ok;
        pass_end  = (cur_rem == REM_ONE);
`ifdef BRAM_RD_STREAMER_LOOP_EN
        final_word = pass_end & (cur_pass <= 8'd1);
`else
        final_word = pass_end;
`endif
    end

    // Next-state for the FSM, address generator and pass bookkeeping.
    always_comb begin
        state_d     = state_q;
        rd_ptr_d    = rd_ptr_q;
        rem_d       = rem_q;
        bram_en_d   = can_issue;
        bram_addr_d = can_issue ? cur_ptr : bram_addr_q;
        last_d      = can_issue & final_word;
`ifdef BRAM_RD_STREAMER_LOOP_EN
        base_d = base_q;
        len_d  = len_q;
        pass_d = pass_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    rd_ptr_d = base_addr;
                    rem_d    = len;
`ifdef BRAM_RD_STREAMER_LOOP_EN
                    base_d = cur_base;
                    len_d  = cur_len;
                    pass_d = cur_pass;
`endif
                    state_d = (len == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN:   state_d = ST_RUN;
            ST_DRAIN: if (fifo_pop & m_last) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        if (can_issue) begin
`ifdef BRAM_RD_STREAMER_LOOP_EN
            if (pass_end & ~final_word) begin
                // Wrap back to the base for the next pass without a bubble.
                rd_ptr_d = cur_base;
                rem_d    = cur_len;
                pass_d   = cur_pass - 8'd1;
            end else begin
                rd_ptr_d = cur_ptr + WID_WADDR'(1);
                rem_d    = cur_rem - REM_ONE;
            end
`else
            rd_ptr_d = cur_ptr + WID_WADDR'(1);
            rem_d    = cur_rem - REM_ONE;
`endif
            if (final_word) begin
                state_d = ST_DRAIN;
            end
        end
    end

    // Control registers.
    always_ff @(posedge clk_l) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            rd_ptr_q    <= '0;
            rem_q       <= '0;
            bram_en_q   <= 1'b0;
            bram_addr_q <= '0;
            last_q      <= 1'b0;
`ifdef BRAM_RD_STREAMER_LOOP_EN
            base_q <= '0;
            len_q  <= '0;
            pass_q <= '0;
`endif
        end else begin
            state_q     <= state_d;
            rd_ptr_q    <= rd_ptr_d;
            rem_q       <= rem_d;
            bram_en_q   <= bram_en_d;
            bram_addr_q <= bram_addr_d;
            last_q      <= last_d;
`ifdef BRAM_RD_STREAMER_LOOP_EN
            base_q <= base_d;
            len_q  <= len_d;
            pass_q <= pass_d;
`endif
        end
    end

    // Read-latency tracker: a word on the bus now reaches bram_dout RD_LAT cycles later.
    always_ff @(posedge clk_l) begin
        if (!rst_n) begin
            trk_vld_q  <= '0;
            trk_last_q <= '0;
        end else begin
            trk_vld_q[0]  <= bram_en_q;
            trk_last_q[0] <= last_q;
            for (int i = 1; i < RD_LAT; i++) begin
                trk_vld_q[i]  <= trk_vld_q[i-1];
                trk_last_q[i] <= trk_last_q[i-1];
            end
        end
    end

    stream_fifo #(
        .WID   (WID_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_l       (clk_l),
        .rst_n       (rst_n),
        .push_i      (fifo_push),
        .push_data_i ({trk_last_q[RD_LAT-1], bram_dout}),
        .pop_i       (fifo_pop),
        .head_o      (fifo_head),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count)
    );

endmodule

// File: tb/tb_bram_rd_streamer.sv
// Randomized self-checking bench for bram_rd_streamer against a queue-based model.
// Covers the loop feature when BRAM_RD_STREAMER_LOOP_EN is defined.
module tb_bram_rd_streamer;

    localparam int DEPTH = 4;

    logic        clk_l = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [9:0]  base_addr = '0;
    logic [10:0] len = '0;
`ifdef BRAM_RD_STREAMER_LOOP_EN
    logic [7:0]  reps = 8'd1;
`endif
    logic        busy, done, bram_en, bram_rst, m_valid, m_last;
    logic        m_ready = 1'b1;
    logic [9:0]  bram_addr;
    logic [15:0] bram_dout, m_data;

    always #5 clk_l = ~clk_l;

    bram_rd_streamer dut (
        .clk_l     (clk_l),
        .rst_n     (rst_n),
        .start     (start),
        .base_addr (base_addr),
        .len       (len),
`ifdef BRAM_RD_STREAMER_LOOP_EN
        .reps      (reps),
`endif
        .busy      (busy),
        .done      (done),
        .bram_addr (bram_addr),
        .bram_en   (bram_en),
        .bram_rst  (bram_rst),
        .bram_dout (bram_dout),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_last    (m_last),
        .m_ready   (m_ready)
    );

    // Behavioural RAMB18 port A: array read on enable, then the DOA output register.
    logic [15:0] mem [1024];
    logic [15:0] ram_q, dout_q;
    always @(posedge clk_l) begin
        if (bram_en) ram_q <= mem[bram_addr];
        dout_q <= ram_q;
    end
    assign bram_dout = dout_q;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected traffic, filled by the model and consumed by the monitor.
    logic [9:0]  exp_addr [$];
    logic [16:0] exp_word [$];

    int cyc = 0, en_total = 0, hs_total = 0, done_cnt = 0;
    int start_cyc = 0, first_valid_cyc = -1, first_hs_cyc = -1, last_hs_cyc = 0;
    int done_cyc = 0, hs_in_pass = 0;
    logic        prev_stall = 1'b0;
    logic [16:0] prev_word = '0;
    bit          ready_rand = 1'b0;

    // Monitor: sample mid-cycle, check addresses, words, credit and stream stability.
    always @(negedge clk_l) begin
        cyc++;
        if (!rst_n) begin
            exp_addr.delete();
            exp_word.delete();
            en_total   = 0;
            hs_total   = 0;
            prev_stall = 1'b0;
        end else begin
            if (start && !busy) begin
                start_cyc       = cyc;
                first_valid_cyc = -1;
                first_hs_cyc    = -1;
                hs_in_pass      = 0;
            end
            if (m_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (prev_stall) begin
                chk("hold_valid", 32'(m_valid), 32'd1);
                chk("hold_data", 32'({m_last, m_data}), 32'(prev_word));
            end
            if (bram_en) begin
                en_total++;
                chk("credit", 32'(en_total - hs_total <= DEPTH), 32'd1);
                if (exp_addr.size() == 0) chk("spurious_en", 32'd1, 32'd0);
                else chk("bram_addr", 32'(bram_addr), 32'(exp_addr.pop_front()));
            end
            if (m_valid && m_ready) begin
                hs_total++;
                hs_in_pass++;
                if (first_hs_cyc < 0) first_hs_cyc = cyc;
                last_hs_cyc = cyc;
                if (exp_word.size() == 0) chk("spurious_word", 32'd1, 32'd0);
                else chk("word", 32'({m_last, m_data}), 32'(exp_word.pop_front()));
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            prev_stall = m_valid && !m_ready;
            prev_word  = {m_last, m_data};
        end
    end

    // Downstream ready: constant 1 or a random pattern.
    initial forever begin
        @(posedge clk_l);
        #1;
        m_ready = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    task automatic tick();
        @(posedge clk_l);
        #2;
    endtask

    // Reference model: reps passes of len sequential words from base, wrapping at 1024.
    task automatic expect_pass(input int b, input int l, input int r);
        int rr;
        int a;
        rr = (r == 0) ? 1 : r;
        for (int p = 0; p < rr; p++) begin
            for (int i = 0; i < l; i++) begin
                a = (b + i) % 1024;
                exp_addr.push_back(10'(a));
                exp_word.push_back({(p == rr - 1) && (i == l - 1), mem[a]});
            end
        end
    endtask

    task automatic run_pass(input string name, input int b, input int l, input int r, input bit rr_en);
        int d0;
        int guard;
        d0 = done_cnt;
        guard = 0;
        expect_pass(b, l, r);
        ready_rand = rr_en;
        base_addr  = 10'(b);
        len        = 11'(l);
`ifdef BRAM_RD_STREAMER_LOOP_EN
        reps = 8'(r);
`endif
        start = 1'b1;
        tick();
        start = 1'b0;
        while (done_cnt == d0 && guard < 6000) begin
            tick();
            guard++;
        end
        chk({name, "_timeout"}, 32'(guard < 6000), 32'd1);
        ready_rand = 1'b0;
        tick();
        tick();
        chk({name, "_done_cnt"}, 32'(done_cnt - d0), 32'd1);
        chk({name, "_left_addr"}, 32'(exp_addr.size()), 32'd0);
        chk({name, "_left_word"}, 32'(exp_word.size()), 32'd0);
        chk({name, "_busy"}, 32'(busy), 32'd0);
        $display("pass %s base=%0d len=%0d reps=%0d words=%0d", name, b, l, r, hs_in_pass);
    endtask

    task automatic chk_reset_outputs(input string name);
        chk({name, "_busy"}, 32'(busy), 32'd0);
        chk({name, "_done"}, 32'(done), 32'd0);
        chk({name, "_bram_en"}, 32'(bram_en), 32'd0);
        chk({name, "_bram_addr"}, 32'(bram_addr), 32'd0);
        chk({name, "_m_valid"}, 32'(m_valid), 32'd0);
        chk({name, "_m_last"}, 32'(m_last), 32'd0);
        chk({name, "_bram_rst"}, 32'(bram_rst), 32'd1);
    endtask

    initial begin
        int d0, e0, g, b;

        for (int i = 0; i < 1024; i++) mem[i] = (i < 48) ? 16'hdddd : 16'h0000;
        tick(); tick(); tick();
        @(negedge clk_l);
        chk_reset_outputs("reset");
        tick();
        rst_n = 1'b1;
        tick();

        // Continuous stream with timing checks.
        run_pass("stream", 0, 64, 1, 1'b0);
        chk("stream_first_valid", 32'(first_valid_cyc - start_cyc), 32'd4);
        chk("stream_first_hs", 32'(first_hs_cyc - start_cyc), 32'd4);
        chk("stream_throughput", 32'(last_hs_cyc - first_hs_cyc), 32'd63);
        chk("stream_words", 32'(hs_in_pass), 32'd64);
        chk("stream_done_lat", 32'(done_cyc - last_hs_cyc), 32'd1);

        for (int i = 0; i < 1024; i++) mem[i] = 16'($urandom);

        // Backpressure.
        b = $urandom_range(0, 1023);
        run_pass("bp", b, 32, 1, 1'b1);
        chk("bp_words", 32'(hs_in_pass), 32'd32);
        run_pass("bp2", $urandom_range(0, 1023), 1 + $urandom_range(0, 40), 1, 1'b1);

        // Address wrap and edge lengths.
        run_pass("wrap", 1020, 8, 1, 1'b0);
        e0 = en_total;
        run_pass("len0", 33, 0, 1, 1'b0);
        chk("len0_done_lat", 32'(done_cyc - start_cyc), 32'd1);
        chk("len0_no_en", 32'(en_total - e0), 32'd0);
        run_pass("len1", 1023, 1, 1, 1'b1);
        run_pass("full", $urandom_range(0, 1023), 1024, 1, 1'b0);
        chk("full_words", 32'(hs_in_pass), 32'd1024);

        // Start during RUN and start coincident with done are both ignored.
        d0 = done_cnt;
        expect_pass(100, 20, 1);
        base_addr = 10'd100;
        len = 11'd20;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        chk("ign_busy", 32'(busy), 32'd1);
        base_addr = 10'd500;
        len = 11'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        g = 0;
        while (!done && g < 2000) begin
            tick();
            g++;
        end
        chk("ign_timeout", 32'(g < 2000), 32'd1);
        base_addr = 10'd700;
        len = 11'd2;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        chk("ign_done_cnt", 32'(done_cnt - d0), 32'd1);
        chk("ign_left_addr", 32'(exp_addr.size()), 32'd0);
        chk("ign_left_word", 32'(exp_word.size()), 32'd0);
        chk("ign_idle", 32'(busy), 32'd0);
        $display("pass ignore_start base=100 len=20 words=%0d", hs_in_pass);

        // Reset at word 10 of 40.
        d0 = done_cnt;
        expect_pass(0, 40, 1);
        base_addr = 10'd0;
        len = 11'd40;
        start = 1'b1;
        tick();
        start = 1'b0;
        g = 0;
        while (hs_in_pass < 10 && g < 500) begin
            tick();
            g++;
        end
        chk("rst_reach10", 32'(g < 500), 32'd1);
        rst_n = 1'b0;
        @(posedge clk_l);
        @(negedge clk_l);
        chk_reset_outputs("midrst");
        tick();
        tick();
        rst_n = 1'b1;
        tick(); tick(); tick();
        chk("midrst_no_done", 32'(done_cnt - d0), 32'd0);
        chk("midrst_idle", 32'(busy), 32'd0);
        $display("pass midreset words_before_reset=%0d", hs_in_pass);
        run_pass("after_rst", 5, 4, 1, 1'b0);
        chk("after_rst_words", 32'(hs_in_pass), 32'd4);

`ifdef BRAM_RD_STREAMER_LOOP_EN
        run_pass("loop", 2, 5, 3, 1'b0);
        chk("loop_words", 32'(hs_in_pass), 32'd15);
        chk("loop_no_bubble", 32'(last_hs_cyc - first_hs_cyc), 32'd14);
        run_pass("loop_bp", 1022, 3, 2, 1'b1);
        run_pass("loop_reps0", 9, 4, 0, 1'b0);
        chk("loop_reps0_words", 32'(hs_in_pass), 32'd4);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "global timeout");
    end

endmodule
